rr_arbiter_lock: RTL and testbench

Parametrised round-robin arbiter for the NOC router output ports. It arbitrates `NUM_REQ` requesters using a rotating one-hot priority pointer and drives a registered one-hot grant. In lock mode it holds the grant for a whole wormhole packet, and a hold limit forces release so that no requester can starve the others. It replaces fixed 4-wide rotating priority registers wherever an output port needs packet-level arbitration.

---
 rtl/rr_arbiter_lock.sv | 169 ++++++++++++++++
 tb/tb_rr_arbiter_lock.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_lock.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_lock
//  Description : Round-robin arbiter with a rotating one-hot priority pointer,
//                a registered one-hot grant, optional packet lock and a hold
//                limit that forces release under contention.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_REQ    number of requesters (>= 2)
//    RESET_PTR  requester index holding highest priority after reset
//    LOCK_EN    1: hold grant while granted request stays high
//               0: re-arbitrate every cycle
//    MAX_HOLD   max consecutive grant cycles while another request is
//               pending (0 = unlimited)
//  Ports
//    clk               clock, all state updates on rising edge
//    reset             synchronous active-high reset
//    req_i             level-sensitive request vector
//    grant_o           registered one-hot grant, zero when idle
//    grant_valid_o     registered OR of grant_o
//    grant_idx_o       binary index of current grant, 0 when idle
//    priority_order_o  registered one-hot priority pointer
// ============================================================================
module rr_arbiter_lock #(
  parameter int NUM_REQ   = 4,
  parameter int RESET_PTR = 2,
  parameter int LOCK_EN   = 1,
  parameter int MAX_HOLD  = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req_i,
  output logic [NUM_REQ-1:0]                            grant_o,
  output logic                                          grant_valid_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx_o,
  output logic [NUM_REQ-1:0]                            priority_order_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  // With MAX_HOLD = 0 the counter has no limit to reach; it simply saturates
  // at its own all-ones value and never triggers expiry.
  localparam logic [HOLD_W-1:0] HOLD_MAX =
    (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD) : {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  localparam logic [NUM_REQ-1:0] VEC_ONE = NUM_REQ'(1);
  localparam logic [NUM_REQ-1:0] PTR_RST = VEC_ONE << RESET_PTR;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  // --------------------------------------------------------------------------
  // Round-robin search
  // --------------------------------------------------------------------------
  // Requests at or above the pointer index take precedence; (ptr - 1)
  // inverted gives a mask of exactly those positions. If none is set there,
  // the search wraps around to the lowest request overall.
  logic [NUM_REQ-1:0]   hi_req;
  logic [NUM_REQ-1:0]   pick_vec;
  logic [NUM_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [NUM_REQ-1:0]   win_next_ptr;

  always_comb begin
    hi_req    = req_i & ~(ptr_q - VEC_ONE);
    pick_vec  = (|hi_req) ? hi_req : req_i;
    win_found = |req_i;
    win_oh    = '0;
    win_idx   = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    // Winner becomes lowest priority: pointer moves one past it.
    win_next_ptr = {win_oh[NUM_REQ-2:0], win_oh[NUM_REQ-1]};
  end

  // --------------------------------------------------------------------------
  // Keep / expiry decision
  // --------------------------------------------------------------------------
  logic other_req;
  logic expired;
  logic keep;

  always_comb begin
    other_req = |(req_i & ~grant_q);
    expired   = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && other_req;
    keep      = (state_q == GRANT) && (LOCK_EN != 0)
                && (|(req_i & grant_q)) && !expired;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    if (keep) begin
      // Locked: only the hold counter moves, saturating at its limit.
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HOLD_ONE;
      end
    end else if (win_found) begin
      state_d = GRANT;
      grant_d = win_oh;
      valid_d = 1'b1;
      idx_d   = win_idx;
      ptr_d   = win_next_ptr;
      hold_d  = HOLD_ONE;
    end else begin
      // Nobody requesting: go idle, pointer keeps its position.
      state_d = IDLE;
      grant_d = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      hold_d  = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant_o          = grant_q;
  assign grant_valid_o    = valid_q;
  assign grant_idx_o      = idx_q;
  assign priority_order_o = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_lock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_lock
//  Description : Self-checking bench for rr_arbiter_lock. Four instances with
//                different configurations share clock and reset; a directed
//                table covers the documented corner cases, then a random run
//                is compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_lock;

  logic clk;
  logic reset;

  logic [7:0] rq [4];

  logic [3:0] req0, req1, req2;
  logic [4:0] req3;
  logic [3:0] g0, g1, g2, p0, p1, p2;
  logic [4:0] g3, p3;
  logic       v0, v1, v2, v3;
  logic [1:0] i0, i1, i2;
  logic [2:0] i3;

  assign req0 = rq[0][3:0];
  assign req1 = rq[1][3:0];
  assign req2 = rq[2][3:0];
  assign req3 = rq[3][4:0];

  // Lock mode, unlimited hold
  rr_arbiter_lock #(.NUM_REQ(4), .RESET_PTR(2), .LOCK_EN(1), .MAX_HOLD(0)) u_lock0 (
    .clk(clk), .reset(reset), .req_i(req0), .grant_o(g0),
    .grant_valid_o(v0), .grant_idx_o(i0), .priority_order_o(p0));
  // No lock: rotates every cycle
  rr_arbiter_lock #(.NUM_REQ(4), .RESET_PTR(2), .LOCK_EN(0)) u_nolock (
    .clk(clk), .reset(reset), .req_i(req1), .grant_o(g1),
    .grant_valid_o(v1), .grant_idx_o(i1), .priority_order_o(p1));
  // Lock mode, hold limit 3
  rr_arbiter_lock #(.NUM_REQ(4), .RESET_PTR(2), .LOCK_EN(1), .MAX_HOLD(3)) u_hold3 (
    .clk(clk), .reset(reset), .req_i(req2), .grant_o(g2),
    .grant_valid_o(v2), .grant_idx_o(i2), .priority_order_o(p2));
  // Non-power-of-two width, pointer resets to the top index
  rr_arbiter_lock #(.NUM_REQ(5), .RESET_PTR(4), .LOCK_EN(1), .MAX_HOLD(2)) u_n5 (
    .clk(clk), .reset(reset), .req_i(req3), .grant_o(g3),
    .grant_valid_o(v3), .grant_idx_o(i3), .priority_order_o(p3));

  logic [7:0] ag [4];
  logic [7:0] ap [4];
  logic [7:0] ai [4];
  logic       av [4];

  assign ag[0] = {4'b0, g0};  assign ap[0] = {4'b0, p0};  assign ai[0] = {6'b0, i0};  assign av[0] = v0;
  assign ag[1] = {4'b0, g1};  assign ap[1] = {4'b0, p1};  assign ai[1] = {6'b0, i1};  assign av[1] = v1;
  assign ag[2] = {4'b0, g2};  assign ap[2] = {4'b0, p2};  assign ai[2] = {6'b0, i2};  assign av[2] = v2;
  assign ag[3] = {3'b0, g3};  assign ap[3] = {3'b0, p3};  assign ai[3] = {5'b0, i3};  assign av[3] = v3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d: got %b expected %b at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int oh_index(input logic [7:0] v);
    int r;
    r = 0;
    for (int b = 0; b < 8; b++) if (v[b]) r = b;
    return r;
  endfunction

  // Compare one instance against an expected grant and pointer; valid and
  // index follow from the expected grant.
  task automatic chk_inst(input string tag, input int k, input logic [7:0] eg, input logic [7:0] ep);
    chk({tag, " grant"}, k, ag[k], eg);
    chk({tag, " valid"}, k, {7'b0, av[k]}, {7'b0, |eg});
    chk({tag, " idx"},   k, ai[k], 8'(oh_index(eg)));
    chk({tag, " ptr"},   k, ap[k], ep);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: grant as an integer index (-1 = idle), pointer index,
  // consecutive-grant count.
  // --------------------------------------------------------------------------
  int NQ [4] = '{4, 4, 4, 5};
  int LK [4] = '{1, 0, 1, 1};
  int MH [4] = '{0, 16, 3, 2};
  int RP [4] = '{2, 2, 2, 4};
  int mg [4];
  int mp [4];
  int mh [4];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mg[k] = -1;
      mp[k] = RP[k];
      mh[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [7:0] req);
    int  n;
    int  g;
    int  other;
    bit  hold_ok;
    n = NQ[k];
    g = mg[k];
    other = 0;
    hold_ok = 0;
    if (g >= 0) begin
      other = int'(req) & ~(1 << g);
      hold_ok = (LK[k] != 0) && req[g] && !(MH[k] != 0 && mh[k] == MH[k] && other != 0);
    end
    if (hold_ok) begin
      if (MH[k] != 0 && mh[k] < MH[k]) mh[k]++;
    end else begin
      mg[k] = -1;
      mh[k] = 0;
      for (int s = 0; s < n; s++) begin
        int c;
        c = (mp[k] + s) % n;
        if (mg[k] < 0 && req[c]) begin
          mg[k] = c;
          mh[k] = 1;
        end
      end
      if (mg[k] >= 0) mp[k] = (mg[k] + 1) % n;
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed table: same reset for all, per-instance requests (u_n5 idle)
  // --------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic [3:0] r0, r1, r2;
    logic [3:0] eg0, ep0, eg1, ep1, eg2, ep2;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [7:0] prev [4];
    logic [7:0] eg;
    logic       do_rst;

    //          rst   r0       r1       r2       g0       p0       g1       p1       g2       p2
    tbl[0]  = '{1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
    tbl[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
    tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b0101, 4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
    tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 4'b0101, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 4'b0101, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    tbl[5]  = '{1'b0, 4'b1011, 4'b1111, 4'b0101, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
    tbl[6]  = '{1'b0, 4'b1011, 4'b1111, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
    tbl[7]  = '{1'b0, 4'b1011, 4'b1111, 4'b0100, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    tbl[8]  = '{1'b0, 4'b1011, 4'b1111, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    tbl[9]  = '{1'b0, 4'b1011, 4'b1111, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
    tbl[10] = '{1'b0, 4'b1011, 4'b1111, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
    tbl[11] = '{1'b0, 4'b1011, 4'b0110, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
    tbl[13] = '{1'b0, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 4'b0010};
    tbl[14] = '{1'b1, 4'b0110, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
    tbl[15] = '{1'b0, 4'b0110, 4'b1011, 4'b0001, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
    tbl[16] = '{1'b0, 4'b0010, 4'b1011, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0001, 4'b0010};

    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst;
      rq[0] = {4'b0, tbl[i].r0};
      rq[1] = {4'b0, tbl[i].r1};
      rq[2] = {4'b0, tbl[i].r2};
      rq[3] = 8'h00;
      @(posedge clk);
      #1;
      chk_inst($sformatf("dir%0d", i), 0, {4'b0, tbl[i].eg0}, {4'b0, tbl[i].ep0});
      chk_inst($sformatf("dir%0d", i), 1, {4'b0, tbl[i].eg1}, {4'b0, tbl[i].ep1});
      chk_inst($sformatf("dir%0d", i), 2, {4'b0, tbl[i].eg2}, {4'b0, tbl[i].ep2});
    end

    // ------------------------------------------------------------------------
    // Random run against the reference model
    // ------------------------------------------------------------------------
    reset = 1'b1;
    for (int k = 0; k < 4; k++) rq[k] = 8'h00;
    @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 4; k++)
      chk_inst("rst", k, 8'h00, 8'(1 << RP[k]));

    for (int cyc = 0; cyc < 3000; cyc++) begin
      do_rst = ($urandom_range(0, 99) == 0);
      reset = do_rst;
      for (int k = 0; k < 4; k++) begin
        // Keep the request vector half of the time so locks and hold
        // limits actually get exercised.
        if ($urandom_range(0, 1) == 0)
          rq[k] = 8'($urandom) & 8'((1 << NQ[k]) - 1);
        prev[k] = rq[k];
      end
      @(posedge clk);
      #1;
      if (do_rst) begin
        model_reset();
      end else begin
        for (int k = 0; k < 4; k++) model_step(k, prev[k]);
      end
      for (int k = 0; k < 4; k++) begin
        eg = (mg[k] >= 0) ? 8'(1 << mg[k]) : 8'h00;
        chk_inst("rnd", k, eg, 8'(1 << mp[k]));
        chk("rnd onehot0", k, {7'b0, $onehot0(ag[k])}, 8'h01);
        chk("rnd idle-grant", k, ag[k] & ~prev[k], 8'h00);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
